tx_fifo_uart: RTL and testbench
===============================

Name: tx_fifo_uart

Overview:
- Downstream consumer of the ASCII sender stage.
- Accepts bytes via push/data handshake into an internal byte FIFO and drives `full` back to the sender.
- Drains the FIFO through an 8N1 UART transmitter with a parameterised baud divider, producing the serial `tx` line to the host.
- Single clock domain; no RX path.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate. DIV = CLK_FREQ/BAUD (integer division) clocks per bit; DIV ≥ 2 required.
- ADDR_W, 4, FIFO address width; FIFO depth = 2**ADDR_W (16).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0), released synchronously to clk.
- push  in  1  write strobe from sender; one byte per cycle while high.
- push_data  in  8  byte to enqueue, sampled with push.
- full  out  1  FIFO holds 2**ADDR_W entries.
- empty  out  1  FIFO holds 0 entries.
- overflow  out  1  sticky: set when push seen while full; cleared only by reset.
- tx  out  1  UART serial output, idle high, registered.
- tx_busy  out  1  high while a frame is in progress (state != IDLE).
- tx_done  out  1  one-cycle pulse in the cycle after each stop bit completes.

Behaviour:
- Reset (rst=0, asynchronous): FIFO pointers and count=0, full=0, empty=1, overflow=0, tx=1, tx_busy=0, tx_done=0, state=IDLE, baud and bit counters=0, shift register=0.
- FIFO:
  - Count has ADDR_W+1 bits; pointers wrap modulo depth.
  - full and empty are decoded from the registered count.
  - Write occurs at the edge where push=1 and full=0.
  - push=1 with full=1: byte dropped, memory and pointers unchanged, overflow set. This holds even if a pop occurs in the same cycle.
  - Simultaneous write and pop: count unchanged, both pointers advance.
  - A pop is issued only by the TX FSM; it is never issued when empty=1.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If empty=0: pop the head byte into the shift register, clear the baud counter, go to START. tx=0 takes effect at this same edge.
  - START: tx=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for DIV cycles per bit, LSB first. Shift right after each bit. After bit 7 go to STOP.
  - STOP: tx=1 for DIV cycles. At the final cycle, pulse tx_done next cycle.
    - If empty=0 at that edge: pop and go directly to START. Back-to-back frames have no idle gap.
    - Otherwise go to IDLE.
- Baud counter: runs 0..DIV-1 only when not in IDLE; resets to 0 on every bit boundary. Every bit is exactly DIV clocks; a frame is exactly 10*DIV clocks.
- Latency: push sampled at edge k into an empty FIFO and idle TX → empty falls after edge k; tx falls after edge k+1.
- tx_busy=1 from the edge entering START until the edge returning to IDLE. It stays 1 across back-to-back frames.
- push_data is not inspected; any 8-bit value is transmitted verbatim.
- Reset mid-frame: tx returns to 1 immediately (asynchronous). Queued data is discarded. No partial frame resumes after release.

Test Plan (CLK_FREQ=100, BAUD=10 → DIV=10, ADDR_W=4):
- Single byte: push 0x35 once with idle TX → tx low 10 clks; then bits 1,0,1,0,1,1,0,0 at 10 clks each; then high 10 clks. tx_done pulses once 100 clks after start. empty=1 after the pop.
- Burst of four bytes 0x30,0x31,0x32,0x33 on consecutive cycles → four contiguous frames, 400 clks total, no idle gap. tx_busy held high for 400 clks. 4 tx_done pulses at 100-clk spacing.
- Fill: push 18 bytes 0x00..0x11 on consecutive cycles → 0x00 popped immediately, 0x01..0x10 stored, full=1 after the 17th push, 0x11 dropped, overflow=1. The serial stream shows 0x00..0x10 in order, and 0x11 never appears.
- Simultaneous push/pop: one byte queued, TX ends its stop bit the same cycle a new push arrives → count stays 1, no byte lost, order preserved.
- Reset mid-frame: assert rst=0 during bit 3 of a frame with 5 bytes queued → tx=1, empty=1, overflow=0, tx_busy=0 immediately. After release, tx stays high with no pushes.
- Pointer wrap: 40 single pushes spaced 120 clks apart → every byte is transmitted correctly across multiple wraps; full never asserts.

Source files
------------

// File: rtl/tx_fifo_uart.sv
// tx_fifo_uart: byte FIFO feeding an 8N1 UART transmitter.
//
// Bytes pushed by the upstream sender are queued in a 2**ADDR_W entry FIFO
// and sent LSB first on `tx`, each frame being one start bit, eight data bits
// and one stop bit. Every bit lasts CLK_FREQ/BAUD clocks. If more data is
// queued when a stop bit ends, the next frame starts with no idle gap.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   push       write strobe, one byte per cycle while high
//   push_data  byte to enqueue, sampled with push
//   full       FIFO holds 2**ADDR_W entries
//   empty      FIFO holds no entries
//   overflow   sticky flag: a push was seen while full
//   tx         serial output, idle high, registered
//   tx_busy    a frame is in progress
//   tx_done    one-cycle pulse after each stop bit completes
module tx_fifo_uart #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned Div   = CLK_FREQ / BAUD;
  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CntW  = (Div > 2) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(Div - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // FIFO storage and bookkeeping
  logic [7:0]        mem_q [Depth];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              wr_en;
  logic              pop;

  // Transmitter state
  state_e            state_q, state_d;
  logic [CntW-1:0]   baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              baud_last;

  // The count never exceeds Depth, so its MSB alone marks the full state.
  assign full     = count_q[ADDR_W];
  assign empty    = (count_q == '0);
  assign overflow = overflow_q;
  assign tx       = tx_q;
  assign tx_busy  = (state_q != StIdle);
  assign tx_done  = done_q;

  // A push while full is dropped even if a pop frees a slot in the same cycle.
  always_comb begin
    wr_en      = push & ~full;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push & full);
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // tx is registered, so each transition loads the level of the bit being
  // entered rather than the bit being left.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    baud_last = (baud_q == BaudLast);
    case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = StData;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_last) begin
          baud_d = '0;
          done_d = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = StStart;
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_tx_fifo_uart.sv
// Bench for tx_fifo_uart with DIV=10, depth 16. A queue/frame-timer model
// predicts every output each cycle; a serial decoder recovers the byte stream
// for comparison against hand-written and model-derived byte lists.
module tb_tx_fifo_uart;

  localparam int DIV = 10;
  localparam int FRAME = 10 * DIV;

  logic       clk;
  logic       rst;
  logic       push;
  logic [7:0] push_data;
  logic       full, empty, overflow, tx, tx_busy, tx_done;

  tx_fifo_uart #(
    .CLK_FREQ(100),
    .BAUD    (10),
    .ADDR_W  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a byte queue plus the position inside the current frame.
  logic [7:0] mq[$];
  logic [7:0] acc[$];
  bit         m_busy = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_done = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_busy = 1'b0;
      m_pos  = 0;
      m_cur  = 8'h00;
      m_ovf  = 1'b0;
      m_done = 1'b0;
    end else begin
      bit full_pre, empty_pre;
      full_pre  = (mq.size() == 16);
      empty_pre = (mq.size() == 0);
      m_done = 1'b0;
      if (m_busy) begin
        m_pos++;
        if (m_pos == FRAME) begin
          m_done = 1'b1;
          if (!empty_pre) begin
            m_cur = mq.pop_front();
            m_pos = 0;
          end else begin
            m_busy = 1'b0;
          end
        end
      end else if (!empty_pre) begin
        m_cur  = mq.pop_front();
        m_busy = 1'b1;
        m_pos  = 0;
      end
      if (push) begin
        if (full_pre) m_ovf = 1'b1;
        else begin
          mq.push_back(push_data);
          acc.push_back(push_data);
        end
      end
    end
  end

  function automatic logic exp_tx();
    int b;
    if (!m_busy) return 1'b1;
    b = m_pos / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    return 1'b1;
  endfunction

  // Per-cycle compare, serial decoder and event counters.
  logic [7:0] rxq[$];
  logic [7:0] exp_q[$];
  int         stamps[$];
  int         rx_pos = -1;
  logic [7:0] rx_sh = 8'h00;
  int         cyc = 0;
  int         done_cnt = 0;
  int         busy_cycles = 0;
  int         tx_low = 0;
  bit         saw_full = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    chk("tx", tx, exp_tx());
    chk("tx_busy", tx_busy, m_busy);
    chk("tx_done", tx_done, m_done);
    chk("full", full, mq.size() == 16);
    chk("empty", empty, mq.size() == 0);
    chk("overflow", overflow, m_ovf);
    if (tx_done) begin
      done_cnt++;
      stamps.push_back(cyc);
    end
    if (tx_busy) busy_cycles++;
    if (!tx) tx_low++;
    if (full) saw_full = 1'b1;
    if (!rst) begin
      rx_pos = -1;
    end else if (rx_pos < 0) begin
      if (!tx) rx_pos = 0;
    end else begin
      rx_pos++;
      if (rx_pos >= DIV + DIV / 2 && rx_pos < 9 * DIV && (rx_pos - DIV / 2) % DIV == 0)
        rx_sh = {tx, rx_sh[7:1]};
      if (rx_pos == 9 * DIV + DIV / 2) begin
        chk("stop_bit", tx, 1'b1);
        rxq.push_back(rx_sh);
        rx_pos = -1;
      end
    end
  end

  task automatic drive(input bit p, input logic [7:0] d);
    @(negedge clk);
    push      = p;
    push_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00);
  endtask

  task automatic clear();
    rxq.delete();
    exp_q.delete();
    stamps.delete();
    acc.delete();
    done_cnt    = 0;
    busy_cycles = 0;
    tx_low      = 0;
    saw_full    = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!(!tx_busy && empty && rx_pos < 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: still busy after %0d cycles", budget);
    end
  endtask

  task automatic chk_rx(input string name);
    chk({name, "_len"}, rxq.size(), exp_q.size());
    for (int i = 0; i < rxq.size() && i < exp_q.size(); i++) chk(name, rxq[i], exp_q[i]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    push = 1'b0;
    push_data = 8'h00;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    rst = 1'b1;
    idle(5);

    // Single byte 0x35: bits 1,0,1,0,1,1,0,0 LSB first.
    clear();
    drive(1'b1, 8'h35);
    idle(5);
    wait_drain(300);
    exp_q = '{8'h35};
    chk_rx("single_rx");
    chk("single_busy", busy_cycles, 100);
    chk("single_done", done_cnt, 1);

    // Burst of four: contiguous frames, 400 busy clocks, done every 100.
    clear();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h30 + 8'(i));
    idle(5);
    wait_drain(1000);
    exp_q = '{8'h30, 8'h31, 8'h32, 8'h33};
    chk_rx("burst_rx");
    chk("burst_busy", busy_cycles, 400);
    chk("burst_done", done_cnt, 4);
    for (int i = 1; i < stamps.size(); i++) chk("burst_spacing", stamps[i] - stamps[i-1], 100);

    // Fill: 0x00 popped at once, 0x01..0x10 stored, 0x11 dropped.
    clear();
    for (int i = 0; i < 17; i++) drive(1'b1, 8'(i));
    drive(1'b1, 8'h11);
    chk("fill_full", full, 1'b1);
    chk("fill_ovf_pre", overflow, 1'b0);
    drive(1'b0, 8'h00);
    chk("fill_ovf", overflow, 1'b1);
    chk("fill_full2", full, 1'b1);
    wait_drain(3000);
    for (int i = 0; i < 17; i++) exp_q.push_back(8'(i));
    chk_rx("fill_rx");

    // Push lands on the edge that ends a stop bit with one byte queued.
    clear();
    drive(1'b1, 8'hA1);
    drive(1'b1, 8'hB2);
    idle(99);
    drive(1'b1, 8'hC3);
    chk("sim_pre_empty", empty, 1'b0);
    chk("sim_pre_tx", tx, 1'b1);
    drive(1'b0, 8'h00);
    chk("sim_done", tx_done, 1'b1);
    chk("sim_empty", empty, 1'b0);
    chk("sim_full", full, 1'b0);
    chk("sim_tx", tx, 1'b0);
    wait_drain(1000);
    exp_q = '{8'hA1, 8'hB2, 8'hC3};
    chk_rx("sim_rx");

    // Reset during data bit 3 with five bytes queued.
    clear();
    for (int i = 0; i < 6; i++) drive(1'b1, 8'h41 + 8'(i));
    idle(40);
    rst = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_ovf", overflow, 1'b0);
    chk("mid_rst_busy", tx_busy, 1'b0);
    idle(3);
    rst = 1'b1;
    clear();
    idle(200);
    chk("post_rst_low", tx_low, 0);
    chk("post_rst_rx", rxq.size(), 0);
    chk("post_rst_done", done_cnt, 0);

    // Pointer wrap: 40 spaced random pushes.
    clear();
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_q.push_back(b);
      drive(1'b1, b);
      idle(119);
    end
    wait_drain(500);
    chk("wrap_no_full", saw_full, 1'b0);
    chk_rx("wrap_rx");

    // Random traffic, including overflow; stream must match accepted bytes.
    clear();
    for (int i = 0; i < 1500; i++) drive($urandom_range(0, 3) == 0, 8'($urandom));
    idle(5);
    wait_drain(3000);
    exp_q = acc;
    chk_rx("rand_rx");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
